// File: rtl/trace_capture_unit_pkg.sv
// Shared types and constants for the trace capture unit: FSM states, trigger
// modes, instruction classes, opcodes and a saturating counter helper.
package trace_capture_unit_pkg;

  localparam int unsigned CLS_W = 3;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned OPC_W = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_POST = 2'd2,
    ST_READ = 2'd3
  } state_t;

  localparam logic [1:0] TRIG_PC     = 2'b00;
  localparam logic [1:0] TRIG_BRANCH = 2'b01;
  localparam logic [1:0] TRIG_EXT    = 2'b10;
  localparam logic [1:0] TRIG_NEVER  = 2'b11;

  localparam logic [CLS_W-1:0] CLS_OTHER  = 3'd0;
  localparam logic [CLS_W-1:0] CLS_BRANCH = 3'd1;
  localparam logic [CLS_W-1:0] CLS_LOAD   = 3'd2;
  localparam logic [CLS_W-1:0] CLS_STORE  = 3'd3;
  localparam logic [CLS_W-1:0] CLS_ALUI   = 3'd4;
  localparam logic [CLS_W-1:0] CLS_ALUR   = 3'd5;

  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_ALUI   = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_ALUR   = 7'b0110011;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/trace_capture_unit_op_class_decode.sv
// Maps a RISC-V major opcode onto the trace unit's 3-bit instruction class.
module op_class_decode
  import trace_capture_unit_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  output logic [CLS_W-1:0] op_class_c
);

  always_comb begin
    op_class_c = CLS_OTHER;
    unique case (opcode)
      OPC_BRANCH: op_class_c = CLS_BRANCH;
      OPC_LOAD:   op_class_c = CLS_LOAD;
      OPC_STORE:  op_class_c = CLS_STORE;
      OPC_ALUI:   op_class_c = CLS_ALUI;
      OPC_ALUR:   op_class_c = CLS_ALUR;
      default:    op_class_c = CLS_OTHER;
    endcase
  end

endmodule

// File: rtl/trace_capture_unit.sv
// Retired-instruction trace buffer: circular pre-trigger capture, fixed-length
// post-trigger capture, then oldest-first readout over a valid/ready port.
module trace_capture_unit
  import trace_capture_unit_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned POST  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cap_valid,
  input  logic [XLEN-1:0]  cap_pc,
  input  logic [XLEN-1:0]  cap_result,
  input  logic [31:0]      cap_instr,
  input  logic             arm,
  input  logic [1:0]       trig_mode,
  input  logic [XLEN-1:0]  trig_pc,
  input  logic             trig_ext,
  output logic [1:0]       state,
  output logic             triggered,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic             rd_last,
  output logic [XLEN-1:0]  rd_pc,
  output logic [XLEN-1:0]  rd_result,
  output logic [31:0]      rd_instr,
  output logic [CLS_W-1:0] rd_class,
  output logic [CNT_W-1:0] cnt_branch,
  output logic [CNT_W-1:0] cnt_load,
  output logic [CNT_W-1:0] cnt_store,
  output logic [CNT_W-1:0] cnt_alu
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  state_t          st;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   post_cnt;
  logic [CW-1:0]   count;
  logic [CW-1:0]   fetch_rem;

  logic [XLEN-1:0]  mem_pc     [DEPTH];
  logic [XLEN-1:0]  mem_result [DEPTH];
  logic [31:0]      mem_instr  [DEPTH];
  logic [CLS_W-1:0] mem_class  [DEPTH];

  logic [CLS_W-1:0] cls;
  logic             capturing;
  logic             hit;
  logic [AW-1:0]    wr_ptr_nx;
  logic [CW-1:0]    count_nx;

  op_class_decode u_decode (
    .opcode     (cap_instr[OPC_W-1:0]),
    .op_class_c (cls)
  );

  assign state     = st;
  assign capturing = cap_valid && ((st == ST_PRE) || (st == ST_POST));
  assign wr_ptr_nx = wr_ptr + AW'(1);
  assign count_nx  = (count == CW'(DEPTH)) ? count : count + CW'(1);

  // Trigger condition for the current sample; only consulted in PRE.
  always_comb begin
    hit = 1'b0;
    unique case (trig_mode)
      TRIG_PC:     hit = (cap_pc == trig_pc);
      TRIG_BRANCH: hit = (cls == CLS_BRANCH);
      TRIG_EXT:    hit = trig_ext;
      TRIG_NEVER:  hit = 1'b0;
      default:     hit = 1'b0;
    endcase
  end

  // Sample buffer: one write port (capture), one read port (readout).
  always_ff @(posedge clk) begin
    if (capturing) begin
      mem_pc[wr_ptr]     <= cap_pc;
      mem_result[wr_ptr] <= cap_result;
      mem_instr[wr_ptr]  <= cap_instr;
      mem_class[wr_ptr]  <= cls;
    end
  end

  // Capture/readout FSM with its pointers, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      st         <= ST_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      post_cnt   <= '0;
      count      <= '0;
      fetch_rem  <= '0;
      triggered  <= 1'b0;
      rd_valid   <= 1'b0;
      rd_last    <= 1'b0;
      rd_pc      <= '0;
      rd_result  <= '0;
      rd_instr   <= '0;
      rd_class   <= '0;
      cnt_branch <= '0;
      cnt_load   <= '0;
      cnt_store  <= '0;
      cnt_alu    <= '0;
    end else begin
      unique case (st)
        ST_IDLE: begin
          if (arm) begin
            st         <= ST_PRE;
            wr_ptr     <= '0;
            count      <= '0;
            triggered  <= 1'b0;
            cnt_branch <= '0;
            cnt_load   <= '0;
            cnt_store  <= '0;
            cnt_alu    <= '0;
          end
        end
        ST_PRE, ST_POST: begin
          if (cap_valid) begin
            wr_ptr <= wr_ptr_nx;
            count  <= count_nx;
            unique case (cls)
              CLS_BRANCH:         cnt_branch <= sat_inc(cnt_branch);
              CLS_LOAD:           cnt_load   <= sat_inc(cnt_load);
              CLS_STORE:          cnt_store  <= sat_inc(cnt_store);
              CLS_ALUI, CLS_ALUR: cnt_alu    <= sat_inc(cnt_alu);
              default: ;
            endcase
            if (st == ST_PRE) begin
              if (hit) begin
                st        <= ST_POST;
                triggered <= 1'b1;
                post_cnt  <= AW'(POST);
              end
            end else begin
              post_cnt <= post_cnt - AW'(1);
              if (post_cnt == AW'(1)) begin
                // Oldest surviving entry sits count_nx slots behind the writer.
                st        <= ST_READ;
                rd_ptr    <= wr_ptr_nx - AW'(count_nx);
                fetch_rem <= count_nx;
              end
            end
          end
        end
        ST_READ: begin
          if (rd_valid && rd_ready && rd_last) begin
            st       <= ST_IDLE;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
          end else if (!rd_valid || rd_ready) begin
            if (fetch_rem != '0) begin
              rd_pc     <= mem_pc[rd_ptr];
              rd_result <= mem_result[rd_ptr];
              rd_instr  <= mem_instr[rd_ptr];
              rd_class  <= mem_class[rd_ptr];
              rd_valid  <= 1'b1;
              rd_last   <= (fetch_rem == CW'(1));
              rd_ptr    <= rd_ptr + AW'(1);
              fetch_rem <= fetch_rem - CW'(1);
            end else begin
              rd_valid <= 1'b0;
            end
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trace_capture_unit.sv
// Scoreboard bench for trace_capture_unit: captured samples are queued as
// expected readout entries and compared in order as the unit drains them.
module tb_trace_capture_unit;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned POST  = 8;

  localparam logic [31:0] I_ADDI = 32'h0010_0093;
  localparam logic [31:0] I_ADD  = 32'h0020_80B3;
  localparam logic [31:0] I_BEQ  = 32'h0000_0063;
  localparam logic [31:0] I_LW   = 32'h0000_2003;
  localparam logic [31:0] I_SW   = 32'h0000_2023;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] result;
    logic [2:0]  cls;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cap_valid = 1'b0;
  logic [31:0] cap_pc = '0, cap_result = '0, cap_instr = '0;
  logic        arm = 1'b0;
  logic [1:0]  trig_mode = 2'b11;
  logic [31:0] trig_pc = '0;
  logic        trig_ext = 1'b0;
  logic [1:0]  state;
  logic        triggered, rd_valid, rd_last;
  logic        rd_ready = 1'b0;
  logic [31:0] rd_pc, rd_result, rd_instr;
  logic [2:0]  rd_class;
  logic [15:0] cnt_branch, cnt_load, cnt_store, cnt_alu;

  int checks = 0;
  int errors = 0;

  // Reference model state
  ent_t        m_q[$];
  int          m_state = 0;
  int          m_post = 0;
  logic        m_trig = 1'b0;
  int          m_br = 0, m_ld = 0, m_st = 0, m_alu = 0;
  logic [31:0] first_pc, last_pc;
  logic [2:0]  class4;

  trace_capture_unit #(.XLEN(32), .DEPTH(DEPTH), .POST(POST)) dut (
    .clk(clk), .reset(reset), .cap_valid(cap_valid), .cap_pc(cap_pc),
    .cap_result(cap_result), .cap_instr(cap_instr), .arm(arm),
    .trig_mode(trig_mode), .trig_pc(trig_pc), .trig_ext(trig_ext),
    .state(state), .triggered(triggered), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .rd_last(rd_last), .rd_pc(rd_pc),
    .rd_result(rd_result), .rd_instr(rd_instr), .rd_class(rd_class),
    .cnt_branch(cnt_branch), .cnt_load(cnt_load), .cnt_store(cnt_store),
    .cnt_alu(cnt_alu)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] exp_class(input logic [31:0] ins);
    logic [6:0] op;
    op = ins[6:0];
    case (op)
      7'h63:   return 3'd1;
      7'h03:   return 3'd2;
      7'h23:   return 3'd3;
      7'h13:   return 3'd4;
      7'h33:   return 3'd5;
      default: return 3'd0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag);
    checks++;
    if (state !== 2'(m_state) || triggered !== m_trig) begin
      errors++;
      $display("FAIL %s status: got state=%0d trig=%0b, expected state=%0d trig=%0b",
               tag, state, triggered, m_state, m_trig);
    end
  endtask

  task automatic check_counters(input string tag);
    checks++;
    if (cnt_branch !== 16'(m_br) || cnt_load !== 16'(m_ld) ||
        cnt_store !== 16'(m_st) || cnt_alu !== 16'(m_alu)) begin
      errors++;
      $display("FAIL %s counters: got br=%0d ld=%0d st=%0d alu=%0d, expected %0d %0d %0d %0d",
               tag, cnt_branch, cnt_load, cnt_store, cnt_alu, m_br, m_ld, m_st, m_alu);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    m_trig = 1'b0;
    m_br = 0; m_ld = 0; m_st = 0; m_alu = 0;
  endtask

  // Drive one cycle of capture input and advance the reference model.
  task automatic send(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                      input logic ext);
    ent_t e;
    logic hit;
    int   prev_state;
    prev_state = m_state;
    cap_valid = v; cap_pc = pc; cap_instr = ins; trig_ext = ext;
    cap_result = $urandom;
    e.pc = pc; e.instr = ins; e.result = cap_result; e.cls = exp_class(ins);
    tick();
    cap_valid = 1'b0; trig_ext = 1'b0;
    if (v && (m_state == 1 || m_state == 2)) begin
      m_q.push_back(e);
      if (m_q.size() > DEPTH) void'(m_q.pop_front());
      case (e.cls)
        3'd1: m_br++;
        3'd2: m_ld++;
        3'd3: m_st++;
        3'd4, 3'd5: m_alu++;
        default: ;
      endcase
      if (m_state == 1) begin
        case (trig_mode)
          2'b00:   hit = (pc == trig_pc);
          2'b01:   hit = (e.cls == 3'd1);
          2'b10:   hit = ext;
          default: hit = 1'b0;
        endcase
        if (hit) begin m_state = 2; m_trig = 1'b1; m_post = POST; end
      end else begin
        m_post--;
        if (m_post == 0) m_state = 3;
      end
    end
    check_status("send");
    if (m_state == 3) begin
      checks++;
      if (rd_valid !== (prev_state == 3)) begin
        errors++;
        $display("FAIL read_start: rd_valid=%0b, expected %0b", rd_valid, prev_state == 3);
      end
    end
  endtask

  task automatic pulse_arm(input string tag);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    if (m_state == 0) begin m_state = 1; model_clear(); end
    check_status(tag);
    check_counters(tag);
  endtask

  // Drain up to max_n entries; mode 0 always ready, 1 toggling, 2 random.
  task automatic drain(input int mode, input int max_n, output int n);
    int          budget;
    logic        ready, xfer, hold;
    logic [31:0] held_pc;
    n = 0; budget = 0; hold = 1'b0; held_pc = '0;
    while (m_q.size() > 0 && n < max_n && budget < 300) begin
      if (hold) begin
        checks++;
        if (!rd_valid || rd_pc !== held_pc) begin
          errors++;
          $display("FAIL hold: rd_valid=%0b rd_pc=%h, expected valid pc=%h", rd_valid, rd_pc, held_pc);
        end
      end
      if (rd_valid) begin
        checks++;
        if (rd_pc !== m_q[0].pc || rd_instr !== m_q[0].instr ||
            rd_result !== m_q[0].result || rd_class !== m_q[0].cls ||
            rd_last !== (m_q.size() == 1)) begin
          errors++;
          $display("FAIL entry%0d: got pc=%h ins=%h res=%h cls=%0d last=%0b, expected pc=%h ins=%h res=%h cls=%0d last=%0b",
                   n, rd_pc, rd_instr, rd_result, rd_class, rd_last, m_q[0].pc,
                   m_q[0].instr, m_q[0].result, m_q[0].cls, m_q.size() == 1);
        end
      end
      case (mode)
        0:       ready = 1'b1;
        1:       ready = (budget % 2 == 0);
        default: ready = 1'($urandom_range(0, 1));
      endcase
      rd_ready = ready;
      xfer = rd_valid && ready;
      hold = rd_valid && !ready;
      held_pc = rd_pc;
      if (xfer) begin
        if (n == 0) first_pc = rd_pc;
        if (n == 3) class4 = rd_class;
        last_pc = rd_pc;
      end
      tick();
      if (xfer) begin void'(m_q.pop_front()); n++; end
      budget++;
    end
    rd_ready = 1'b0;
    if (budget >= 300) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d entries after %0d cycles", n, budget);
    end
    if (m_q.size() == 0) begin
      m_state = 0;
      checks++;
      if (state !== 2'd0 || rd_valid !== 1'b0) begin
        errors++;
        $display("FAIL read_end: state=%0d rd_valid=%0b, expected 0 0", state, rd_valid);
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rd_ready = 1'b0;
    tick();
    m_state = 0; model_clear();
    checks++;
    if (state !== 2'd0 || rd_valid !== 1'b0 || rd_last !== 1'b0 || triggered !== 1'b0 ||
        rd_pc !== '0 || rd_result !== '0 || rd_instr !== '0 || rd_class !== '0) begin
      errors++;
      $display("FAIL reset_outputs: state=%0d rd_valid=%0b rd_last=%0b trig=%0b rd_pc=%h, expected all 0",
               state, rd_valid, rd_last, triggered, rd_pc);
    end
    check_counters("reset");
    reset = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    do_reset();
  endtask

  task automatic test_pc_trigger();
    int n;
    trig_mode = 2'b00; trig_pc = 32'h20;
    pulse_arm("arm_pc");
    for (int i = 0; i < 32; i++) send(1'b1, 32'(i * 4), I_ADDI, 1'b0);
    check_counters("pc_cnt");
    checks++;
    if (cnt_alu !== 16'd17) begin
      errors++; $display("FAIL pc_alu: got %0d expected 17", cnt_alu);
    end
    drain(1, 100, n);
    checks++;
    if (n != 16 || first_pc !== 32'h04 || last_pc !== 32'h40) begin
      errors++;
      $display("FAIL pc_window: n=%0d first=%h last=%h, expected 16 04 40", n, first_pc, last_pc);
    end
  endtask

  task automatic test_branch_trigger();
    int n;
    trig_mode = 2'b01;
    pulse_arm("arm_br");
    for (int i = 0; i < 3; i++) send(1'b1, 32'h100 + 32'(i * 4), I_ADDI, 1'b0);
    send(1'b1, 32'h10C, I_BEQ, 1'b0);
    for (int i = 0; i < 8; i++) send(1'b1, 32'h110 + 32'(i * 4), I_LW, 1'b0);
    check_counters("br_cnt");
    checks++;
    if (cnt_branch !== 16'd1 || cnt_load !== 16'd8 || cnt_alu !== 16'd3 || cnt_store !== 16'd0) begin
      errors++;
      $display("FAIL br_counts: got %0d %0d %0d %0d, expected 1 8 3 0",
               cnt_branch, cnt_load, cnt_alu, cnt_store);
    end
    drain(0, 100, n);
    checks++;
    if (n != 12 || class4 !== 3'd1) begin
      errors++; $display("FAIL br_entries: n=%0d class4=%0d, expected 12 1", n, class4);
    end
  endtask

  task automatic test_ext_gaps();
    int n;
    trig_mode = 2'b10;
    pulse_arm("arm_ext");
    for (int i = 0; i < 14; i++) begin
      send(1'b1, 32'h300 + 32'(i * 4), I_LW, i == 1);
      send(1'b0, 32'hDEAD_0000, I_BEQ, 1'b1);
    end
    check_counters("ext_cnt");
    drain(2, 100, n);
    checks++;
    if (n != 2 + POST) begin
      errors++; $display("FAIL ext_entries: n=%0d expected %0d", n, 2 + POST);
    end
  endtask

  task automatic test_arm_ignored();
    int n;
    trig_mode = 2'b10;
    pulse_arm("arm_ign");
    send(1'b1, 32'h400, I_ADD, 1'b0);
    send(1'b1, 32'h404, I_SW, 1'b0);
    pulse_arm("arm_in_pre");
    send(1'b1, 32'h408, I_BEQ, 1'b1);
    send(1'b1, 32'h40C, I_ADD, 1'b0);
    send(1'b1, 32'h410, I_LW, 1'b0);
    pulse_arm("arm_in_post");
    for (int i = 0; i < 6; i++) send(1'b1, 32'h414 + 32'(i * 4), I_SW, 1'b0);
    check_counters("ign_cnt");
    drain(0, 100, n);
    checks++;
    if (n != 11) begin
      errors++; $display("FAIL ign_entries: n=%0d expected 11", n);
    end
  endtask

  task automatic test_free_run();
    trig_mode = 2'b11;
    pulse_arm("arm_free");
    for (int i = 0; i < 20; i++) send(1'b1, 32'h20 + 32'(i * 4), I_ADD, 1'b1);
    pulse_arm("arm_free_again");
    send(1'b1, 32'h20, I_ADD, 1'b1);
    check_counters("free_cnt");
    checks++;
    if (state !== 2'd1 || cnt_alu !== 16'd21) begin
      errors++; $display("FAIL free_run: state=%0d alu=%0d, expected 1 21", state, cnt_alu);
    end
    do_reset();
  endtask

  task automatic test_reset_mid_read();
    int n;
    trig_mode = 2'b10;
    pulse_arm("arm_rr");
    for (int i = 0; i < 9; i++) send(1'b1, 32'h500 + 32'(i * 4), I_ADDI, i == 0);
    drain(0, 3, n);
    checks++;
    if (n != 3 || state !== 2'd3) begin
      errors++; $display("FAIL partial_read: n=%0d state=%0d, expected 3 3", n, state);
    end
    do_reset();
    trig_mode = 2'b00; trig_pc = 32'h208;
    pulse_arm("rearm");
    for (int i = 0; i < 12; i++) send(1'b1, 32'h200 + 32'(i * 4), I_SW, 1'b0);
    check_counters("rearm_cnt");
    checks++;
    if (cnt_store !== 16'd11 || cnt_alu !== 16'd0) begin
      errors++; $display("FAIL rearm_counts: st=%0d alu=%0d, expected 11 0", cnt_store, cnt_alu);
    end
    drain(1, 100, n);
    checks++;
    if (n != 11 || first_pc !== 32'h200) begin
      errors++; $display("FAIL rearm_entries: n=%0d first=%h, expected 11 200", n, first_pc);
    end
  endtask

  initial begin
    test_reset();
    test_pc_trigger();
    test_branch_trigger();
    test_ext_gaps();
    test_arm_ignored();
    test_free_run();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/trace_capture_unit.md
TRACE_CAPTURE_UNIT -- requirements
Module: trace_capture_unit

Interface
REQ-001 Parameters: XLEN, default 32, datapath width; DEPTH, default 16, buffer entries (power of 2, 4..256); POST, default 8, post-trigger samples (1..DEPTH-1).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 cap_valid  in  1  one retired-instruction sample present this cycle.
REQ-005 cap_pc / cap_result  in  XLEN each  sample PC / ALU result.
REQ-006 cap_instr  in  32  sample instruction word.
REQ-007 arm  in  1  start-capture pulse.
REQ-008 trig_mode  in  2  00 PC match, 01 branch class, 10 external, 11 never (free-run).
REQ-009 trig_pc  in  XLEN  PC compare value; trig_ext  in  1  external trigger.
REQ-010 state  out  2  IDLE=0, PRE=1, POST=2, READ=3; triggered  out  1  trigger seen since arm.
REQ-011 rd_valid  out  1 / rd_ready  in  1  readout handshake; rd_last  out  1  final entry.
REQ-012 rd_pc, rd_result  out  XLEN; rd_instr  out  32; rd_class  out  3  entry data.
REQ-013 cnt_branch, cnt_load, cnt_store, cnt_alu  out  16 each  class counters.

Function
REQ-014 Class decode on opcode [6:0]: 1100011 BRANCH=1, 0000011 LOAD=2, 0000011-excluded 0100011 STORE=3, 0010011 ALUI=4, 0110011 ALUR=5, else OTHER=0.
REQ-015 IDLE: no writes; arm=1 -> PRE, clears write pointer, entry count, triggered, all class counters.
REQ-016 arm while not IDLE: ignored.
REQ-017 PRE/POST: each cap_valid=1 cycle writes {pc,instr,result,class} at write pointer, pointer wraps modulo DEPTH, oldest entry overwritten; entry count saturates at DEPTH.
REQ-018 cap_valid=0 cycles: no write, no trigger evaluation, no counter change.
REQ-019 Trigger evaluated only on a valid sample in PRE: mode 00 cap_pc==trig_pc; 01 class BRANCH; 10 trig_ext=1; 11 never.
REQ-020 Triggering sample is stored; state -> POST, triggered=1; post counter loads POST.
REQ-021 POST: each further stored sample decrements post counter; store of POST-th sample -> READ next cycle.
REQ-022 Mode 11: capture continues in PRE until next reset; arm ignored as per REQ-016.
REQ-023 Class counters increment in PRE/POST per valid sample of BRANCH, LOAD, STORE, ALUI/ALUR (alu); saturate at 16'hFFFF.
REQ-024 READ: entries delivered oldest first, start index = write pointer - entry count (mod DEPTH), entry count items total.
REQ-025 rd_valid first asserts one cycle after entering READ (registered buffer read).
REQ-026 rd_valid, data held stable until rd_ready=1; transfer on rd_valid&rd_ready; next entry valid the following cycle at the earliest, back-to-back allowed at 1 entry/cycle.
REQ-027 rd_last=1 with final entry; its transfer -> IDLE next cycle, rd_valid=0.
REQ-028 Samples arriving in READ/IDLE: discarded.

Reset
REQ-029 reset=1: state IDLE, pointers/counts/post counter 0, triggered 0, rd_valid 0, rd_last 0, rd_* data 0, class counters 0.
REQ-030 reset overrides all activity, including mid-capture and mid-readout; buffer contents need not clear.

Structure
REQ-031 Shared package holds state enum, trig_mode encodings, class encodings, opcode constants.
REQ-032 One sub-module op_class_decode (combinational instr -> 3-bit class); buffer as inferred dual-port array.

Verification
REQ-033 Mode 00, trig_pc=0x20, PCs 0x00..0x7C step 4, POST=8: 17 entries expected capped at 16, readout PCs 0x24..0x40 preceded by 0x04..0x20 -> first rd_pc=0x04, rd_last at 0x40.
REQ-034 Mode 01, 3 ALUI then BEQ then 8 LW: 12 entries, cnt_branch=1, cnt_load=8, cnt_alu=3, rd_class of entry 4 = 1.
REQ-035 Mode 10, trig_ext on valid sample 2 with cap_valid gaps every other cycle: exactly 2+POST entries, gaps never stored.
REQ-036 Readout with rd_ready toggling 1/0: rd_pc stable while rd_ready=0, no entry lost or duplicated.
REQ-037 reset pulsed mid-READ after 3 transfers: next cycle state=0, rd_valid=0; re-arm captures fresh, counters 0.
REQ-038 arm pulsed in PRE and POST: no state, pointer or counter change.
